// File: rtl/mod_exp_seq_pkg.sv
// Shared types and constants for the modular exponent sequencer.
// Redundant signed-digit values are vectors of sd2_t, LSD first.
package mod_exp_seq_pkg;

  typedef struct packed {
    logic pos;
    logic neg;
  } sd2_t;

  localparam logic ALU_MUL = 1'b0;
  localparam logic ALU_ADD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL,
    ST_DONE
  } mod_exp_state_t;

  // Digit idx of the constant one, for a vector of any width.
  function automatic sd2_t SD2_ONE(input int unsigned idx);
    sd2_t d;
    d.pos = (idx == 0);
    d.neg = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/mod_exp_seq_op_timer.sv
// Op timer: counts 0..LAT while run is high, done on count LAT.
// Wraps straight back to 0 so consecutive ops have no bubble.
module op_timer #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic done
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = run && (cnt_q == CW'(LAT));
    cnt_d = cnt_q;
    if (!run || done) cnt_d = '0;
    else              cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply sequencer driving a shared
// mod_alu; returns base^exp mod m in redundant signed-digit form.
module mod_exp_seq
  import mod_exp_seq_pkg::*;
#(
  parameter int N   = 256,
  parameter int E   = 16,
  parameter int LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  sd2_t [N-1:0]   base,
  input  logic [E-1:0]   exp,
  input  sd2_t [N-1:0]   m,
  output logic           out_valid,
  input  logic           out_ready,
  output sd2_t [N:0]     result,
  output logic           alu_mode,
  output sd2_t [N-1:0]   alu_m,
  output sd2_t [N-1:0]   alu_x,
  output sd2_t [N-1:0]   alu_y,
  input  sd2_t [N:0]     alu_z
);

  localparam int IW = (E > 1) ? $clog2(E) : 1;

  mod_exp_state_t state_q, state_d;
  sd2_t [N:0]     acc_q, acc_d;
  sd2_t [N-1:0]   base_q, base_d;
  sd2_t [N-1:0]   m_q, m_d;
  logic [E-1:0]   exp_q, exp_d;
  logic [IW-1:0]  i_q, i_d;

  sd2_t [N:0]     acc_one;
  logic           busy;
  logic           op_done;
  logic           last;

  op_timer #(
    .LAT (LAT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (busy),
    .done (op_done)
  );

  always_comb begin
    acc_one = '0;
    for (int d = 0; d <= N; d++) acc_one[d] = SD2_ONE(d);
  end

  assign busy = (state_q == ST_SQR) || (state_q == ST_MUL);
  assign last = (i_q == '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    m_d     = m_q;
    exp_d   = exp_q;
    i_d     = i_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          base_d  = base;
          m_d     = m;
          exp_d   = exp;
          acc_d   = acc_one;
          i_d     = IW'(E - 1);
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        if (op_done) begin
          acc_d = alu_z;
          if (exp_q[i_q]) begin
            state_d = ST_MUL;
          end else if (!last) begin
            i_d = i_q - IW'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (op_done) begin
          acc_d = alu_z;
          if (!last) begin
            i_d     = i_q - IW'(1);
            state_d = ST_SQR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the low N digits feed the ALU; digit N stays redundant-zero.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = out_valid ? acc_q : '0;
    alu_mode  = ALU_MUL;
    alu_m     = m_q;
    alu_x     = busy ? acc_q[N-1:0] : '0;
    alu_y     = '0;
    if (state_q == ST_SQR) alu_y = acc_q[N-1:0];
    if (state_q == ST_MUL) alu_y = base_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      m_q     <= '0;
      exp_q   <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      i_q     <= i_d;
    end
  end

endmodule

// File: doc/mod_exp_seq.md
# mod_exp_seq

Sequencer that computes modular exponentiation `base^exp mod m` with left-to-right square-and-multiply. It reuses one `mod_alu` instance in the same clock domain as the shared datapath. The block accepts jobs over a valid/ready input, issues operand pairs to the ALU, and holds each pair stable for the ALU's fixed latency. It returns the redundant signed-digit result over a valid/ready output. It is the first controller layered on `mod_alu` and owns that ALU exclusively.

## Interface

- `N`, 256: operand width in `sd2_t` digits; must match the `mod_alu` instance.
- `E`, 16: exponent width in plain binary bits; E ≥ 1.
- `LAT`, 4: `mod_alu` latency, the number of cycles from operands applied to `z` valid; LAT ≥ 1.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: job request.
- `in_ready` out 1: job accepted when `in_valid & in_ready`.
- `base` in `sd2_t[N-1:0]`: base operand.
- `exp` in `[E-1:0]`: exponent, unsigned binary.
- `m` in `sd2_t[N-1:0]`: modulus.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out `sd2_t[N:0]`: `base^exp mod m`, in redundant form.
- `alu_mode` out 1: `ALU_MUL` (1'b0) is the only mode this block issues.
- `alu_m` out `sd2_t[N-1:0]`: latched modulus.
- `alu_x`, `alu_y` out `sd2_t[N-1:0]`: ALU operands.
- `alu_z` in `sd2_t[N:0]`: ALU result.

## Operation

- States: IDLE, SQR, MUL, DONE.
- **IDLE**
  - `in_ready`=1.
  - On accept: latch `base`, `exp`, `m`; set acc = `SD2_ONE` (digit 0 = pos, all others zero); set i = E-1; go to SQR.
- **SQR**
  - Drive x = acc[N-1:0], y = acc[N-1:0].
  - On op completion: acc ← `alu_z`.
  - Next state: MUL if exp[i]; otherwise SQR with i-1 if i>0; otherwise DONE.
- **MUL**
  - Drive x = acc[N-1:0], y = base.
  - On op completion: acc ← `alu_z`.
  - Next state: SQR with i-1 if i>0; otherwise DONE.
- **DONE**
  - `out_valid`=1 and `result`=acc.
  - On `out_ready`, go to IDLE.
- Squaring 1 is harmless; leading zero exponent bits are not skipped, so the cycle count is data-dependent only through the popcount of `exp`.
- `acc` is N+1 digits wide. Only digits [N-1:0] feed the ALU; the ALU contract keeps digit N redundant-zero, which permits this truncation.
- `in_valid` asserted outside IDLE is ignored: no latch, no side effect.
- `base`, `exp`, `m` may change after accept with no effect on the job in progress.

## Timing

- `in_ready`, `out_valid`, `result` are decoded from registered state and acc only; there are no combinational input-to-output paths.
- An op timer counts 0..LAT. Operands are stable from count 0 through count LAT.
- `alu_z` is sampled on the edge that ends count LAT. Each op therefore occupies LAT+1 cycles.
- The next op's operands appear on the cycle immediately after sampling; there are no bubbles.
- Latency from accept edge to first `out_valid` cycle is (E + popcount(exp))·(LAT+1) cycles.
- `result` is stable while `out_valid` && !`out_ready`.
- The DONE→IDLE transition costs one cycle, so a new accept happens no earlier than the cycle after the result handshake.
- Reset values:
  - state IDLE; `in_ready`=1 in the first cycle after reset.
  - `out_valid`=0.
  - `result` all zero.
  - `alu_x`, `alu_y`, `alu_m` all zero.
  - `alu_mode`=`ALU_MUL`.
  - timer=0.
- `rst` asserted mid-job aborts on that edge: no result is produced and latched operands are discarded.

## Structure

- Shared `pkg` gains:
  - `ALU_MUL`/`ALU_ADD` mode constants.
  - `SD2_ONE` helper function, parameterised by width.
  - `mod_exp_state_t` enum.
- `sd2_t` remains defined in `pkg`.
- A single sub-module, `op_timer` (LAT+1 counter with `start`/`done`), is natural. Everything else lives in `mod_exp_seq`.

## Test plan

All checks use a behavioral `mod_alu` model (multiply mod m, LAT-cycle delay, non-canonical redundant output). The bench converts results with `sd2tobin` and compares mod m. Configuration for all scenarios: N=8, E=4, LAT=3, m=251.

1. base=3, exp=0 → value 1; `out_valid` exactly 16 cycles after accept.
2. base=3, exp=5 → 243; 24 cycles. Operands stay stable for 4 cycles per op, and the op sequence is S, S, M, S, S, M.
3. base=2, exp=8 → 256 mod 251 = 5; 20 cycles.
4. `out_ready` held low 5 cycles in DONE → `result` unchanged, `in_ready`=0, and an `in_valid` pulse in that window is ignored. After the handshake plus 1 cycle, `in_ready`=1.
5. `rst` pulsed for 1 cycle at cycle 10 of scenario 2 → next cycle state IDLE, `out_valid`=0, `alu_x`=0. A fresh job (base=2, exp=8) then yields 5.
6. Back-to-back jobs with `out_ready` tied high → the second accept lands 2 cycles after the first `out_valid` rises (handshake cycle, then IDLE cycle), and both results are correct.
